tlb_lru_update: RTL and testbench

TLB_LRU_UPDATE -- requirements
Module: tlb_lru_update

---
 rtl/tlb_lru_update_if.sv | 26 ++
 rtl/tlb_lru_update.sv | 201 ++++++++++++++++++++
 tb/tb_tlb_lru_update.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tlb_lru_update_if.sv
// Request channel of the TLB LRU updater: one touch/invalidate per accepted handshake.
interface tlb_lru_update_if #(
    parameter int SET_BITS = 4
) ();
    logic                req_valid;
    logic                req_ready;
    logic                req_op;
    logic [SET_BITS-1:0] req_set;
    logic [1:0]          req_way;

    modport master (
        output req_valid,
        output req_op,
        output req_set,
        output req_way,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_op,
        input  req_set,
        input  req_way,
        output req_ready
    );
endinterface

// File: rtl/tlb_lru_update.sv
// Per-set LRU recency counters for a 4-way TLB: touch promotes a way to most recent,
// invalidate demotes it; saturation is resolved by rank-compressing the set.
module tlb_lru_update #(
    parameter int NUM_SETS = 16,
    parameter int SET_BITS = 4,
    parameter int NUM_WAYS = 4,
    parameter int LRU_BITS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    tlb_lru_update_if.slave              req,
    input  logic [SET_BITS-1:0]          rd_set,
    output logic [NUM_WAYS*LRU_BITS-1:0] rd_lru_count,
    output logic                         renorm
);
    localparam int ROW_BITS = NUM_WAYS * LRU_BITS;

    typedef enum logic [1:0] {INIT, IDLE, RENORM, APPLY} state_t;

    state_t               state_reg;
    logic [SET_BITS-1:0]  sweep_idx_reg;
    logic [SET_BITS-1:0]  set_reg;
    logic [1:0]           way_reg;
    logic                 op_reg;
    logic                 req_ready_reg;
    logic                 renorm_reg;
    logic [ROW_BITS-1:0]  rd_lru_count_reg;

    logic [ROW_BITS-1:0]  mem [NUM_SETS];

    logic [SET_BITS-1:0]  rmw_set;
    logic [1:0]           way_sel;
    logic [ROW_BITS-1:0]  cur_row;
    logic [ROW_BITS-1:0]  rank_row;
    logic [LRU_BITS-1:0]  cnt [NUM_WAYS];
    logic [LRU_BITS-1:0]  max_cnt;
    logic [2:0]           n_max;
    logic                 unique_max;
    logic                 accept;
    logic                 renorm_go;

    logic                 wr_en;
    logic [SET_BITS-1:0]  wr_addr;
    logic [ROW_BITS-1:0]  wr_data;
    logic                 set_val;
    logic [LRU_BITS-1:0]  new_val;

    // In IDLE the row is read for the incoming request; later states reuse the latched target.
    assign rmw_set    = (state_reg == IDLE) ? req.req_set : set_reg;
    assign way_sel    = (state_reg == IDLE) ? req.req_way : way_reg;
    assign cur_row    = mem[rmw_set];
    assign accept     = req.req_valid && req_ready_reg;
    assign unique_max = (cnt[way_sel] == max_cnt) && (n_max == 3'd1);
    assign renorm_go  = accept && !req.req_op && !unique_max && (max_cnt == '1);

    generate
        for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way
            logic [LRU_BITS-1:0] rank;

            assign cnt[gi] = cur_row[gi*LRU_BITS +: LRU_BITS];

            // Ties broken by way index so the ranks are always a permutation of 0..NUM_WAYS-1.
            always_comb begin
                rank = '0;
                for (int j = 0; j < NUM_WAYS; j++) begin
                    if ((cnt[j] < cnt[gi]) || ((cnt[j] == cnt[gi]) && (j < gi))) begin
                        rank = rank + 1'b1;
                    end
                end
            end

            assign rank_row[gi*LRU_BITS +: LRU_BITS] = rank;
        end
    endgenerate

    always_comb begin
        max_cnt = '0;
        n_max   = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (cnt[i] > max_cnt) begin
                max_cnt = cnt[i];
            end
        end
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (cnt[i] == max_cnt) begin
                n_max = n_max + 3'd1;
            end
        end
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = rmw_set;
        wr_data = cur_row;
        set_val = 1'b0;
        new_val = '0;
        case (state_reg)
            INIT: begin
                wr_en   = 1'b1;
                wr_addr = sweep_idx_reg;
                wr_data = '0;
            end
            IDLE: begin
                if (accept) begin
                    if (req.req_op) begin
                        set_val = 1'b1;
                    end else if (!unique_max && (max_cnt != '1)) begin
                        set_val = 1'b1;
                        new_val = max_cnt + 1'b1;
                    end
                end
            end
            RENORM: begin
                wr_en   = 1'b1;
                wr_data = rank_row;
            end
            APPLY: begin
                if (!op_reg) begin
                    set_val = 1'b1;
                    new_val = LRU_BITS'(NUM_WAYS);
                end
            end
            default: ;
        endcase
        if (set_val) begin
            wr_en = 1'b1;
            for (int i = 0; i < NUM_WAYS; i++) begin
                if (i == int'(way_sel)) begin
                    wr_data[i*LRU_BITS +: LRU_BITS] = new_val;
                end
            end
        end
        if (rst) begin
            wr_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read sees the pre-write row when the same set is being updated.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_lru_count_reg <= '0;
        end else begin
            rd_lru_count_reg <= mem[rd_set];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= INIT;
            sweep_idx_reg <= '0;
            set_reg       <= '0;
            way_reg       <= '0;
            op_reg        <= 1'b0;
            req_ready_reg <= 1'b0;
            renorm_reg    <= 1'b0;
        end else begin
            case (state_reg)
                INIT: begin
                    sweep_idx_reg <= sweep_idx_reg + 1'b1;
                    if (sweep_idx_reg == SET_BITS'(NUM_SETS - 1)) begin
                        state_reg     <= IDLE;
                        req_ready_reg <= 1'b1;
                    end
                end
                IDLE: begin
                    if (accept) begin
                        set_reg <= req.req_set;
                        way_reg <= req.req_way;
                        op_reg  <= req.req_op;
                        if (renorm_go) begin
                            state_reg     <= RENORM;
                            req_ready_reg <= 1'b0;
                            renorm_reg    <= 1'b1;
                        end
                    end
                end
                RENORM: begin
                    state_reg  <= APPLY;
                    renorm_reg <= 1'b0;
                end
                APPLY: begin
                    state_reg     <= IDLE;
                    req_ready_reg <= 1'b1;
                end
                default: begin
                    state_reg <= INIT;
                end
            endcase
        end
    end

    assign req.req_ready = req_ready_reg;
    assign renorm        = renorm_reg;
    assign rd_lru_count  = rd_lru_count_reg;
endmodule

// File: tb/tb_tlb_lru_update.sv
// Directed bench for tlb_lru_update: reset sweep, touch/invalidate, renormalisation and read timing.
module tb_tlb_lru_update;
    logic        clk;
    logic        rst;
    logic [3:0]  rd_set;
    logic [15:0] rd_lru_count;
    logic        renorm;

    int checks;
    int errors;

    tlb_lru_update_if #(.SET_BITS(4)) req_if ();

    tlb_lru_update #(
        .NUM_SETS(16),
        .SET_BITS(4),
        .NUM_WAYS(4),
        .LRU_BITS(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req_if.slave),
        .rd_set      (rd_set),
        .rd_lru_count(rd_lru_count),
        .renorm      (renorm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All tasks start and end at posedge+1 so inputs never change at an active edge.
    task automatic do_req(input logic op, input logic [3:0] set, input logic [1:0] way);
        int n;
        n = 0;
        while (!req_if.req_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL req_wait: req_ready=%b after %0d cycles, required 1", req_if.req_ready, n);
        end
        req_if.req_valid = 1'b1;
        req_if.req_op    = op;
        req_if.req_set   = set;
        req_if.req_way   = way;
        @(posedge clk); #1;
        req_if.req_valid = 1'b0;
        $display("req op=%0d set=%0d way=%0d", op, set, way);
    endtask

    task automatic read_set(input logic [3:0] set, output logic [15:0] row);
        rd_set = set;
        @(posedge clk); #1;
        row = rd_lru_count;
        $display("read set=%0d row=%h", set, row);
    endtask

    // Alternating touches starting with way 1 leave the set at [14,15,0,0].
    task automatic fill_alt(input logic [3:0] set);
        for (int k = 0; k < 15; k++) begin
            do_req(1'b0, set, (k % 2 == 0) ? 2'd1 : 2'd0);
        end
    endtask

    task automatic wait_sweep();
        logic [15:0] row;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            checks++;
            if (req_if.req_ready !== (c == 16)) begin
                errors++;
                $display("FAIL sweep_ready: cycle %0d req_ready=%b, required %b", c, req_if.req_ready, (c == 16));
            end
        end
        for (int s = 0; s < 16; s++) begin
            read_set(4'(s), row);
            checks++;
            if (row !== 16'h0000) begin
                errors++;
                $display("FAIL sweep_clear: set %0d row=%h, required 0000", s, row);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (req_if.req_ready !== 1'b0 || renorm !== 1'b0 || rd_lru_count !== 16'h0000) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b renorm=%b rd=%h, required 0 0 0000",
                     req_if.req_ready, renorm, rd_lru_count);
        end
        rst = 1'b0;
        wait_sweep();
    endtask

    task automatic test_back_to_back();
        logic [15:0] row;
        req_if.req_valid = 1'b1;
        req_if.req_op    = 1'b0;
        req_if.req_set   = 4'd2;
        for (int w = 0; w < 4; w++) begin
            req_if.req_way = 2'(w);
            @(posedge clk); #1;
            $display("req op=0 set=2 way=%0d", w);
            checks++;
            if (req_if.req_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready: after way %0d req_ready=%b, required 1", w, req_if.req_ready);
            end
        end
        req_if.req_valid = 1'b0;
        read_set(4'd2, row);
        checks++;
        if (row !== 16'h4321) begin
            errors++;
            $display("FAIL b2b_row: set 2 row=%h, required 4321", row);
        end
    endtask

    task automatic test_touch_max_inval();
        logic [15:0] row;
        do_req(1'b0, 4'd2, 2'd3);
        read_set(4'd2, row);
        checks++;
        if (row !== 16'h4321) begin
            errors++;
            $display("FAIL touch_unique_max: set 2 row=%h, required 4321", row);
        end
        do_req(1'b1, 4'd2, 2'd1);
        read_set(4'd2, row);
        checks++;
        if (row !== 16'h4301) begin
            errors++;
            $display("FAIL invalidate: set 2 row=%h, required 4301", row);
        end
    endtask

    task automatic test_renorm();
        logic [15:0] row;
        fill_alt(4'd3);
        read_set(4'd3, row);
        checks++;
        if (row !== 16'h00FE) begin
            errors++;
            $display("FAIL renorm_fill: set 3 row=%h, required 00fe", row);
        end
        rd_set           = 4'd3;
        req_if.req_valid = 1'b1;
        req_if.req_op    = 1'b0;
        req_if.req_set   = 4'd3;
        req_if.req_way   = 2'd2;
        @(posedge clk); #1;
        req_if.req_valid = 1'b0;
        $display("req op=0 set=3 way=2 (renormalising)");
        checks++;
        if (req_if.req_ready !== 1'b0 || renorm !== 1'b1) begin
            errors++;
            $display("FAIL renorm_enter: ready=%b renorm=%b, required 0 1", req_if.req_ready, renorm);
        end
        @(posedge clk); #1;
        checks++;
        if (req_if.req_ready !== 1'b0 || renorm !== 1'b0) begin
            errors++;
            $display("FAIL renorm_apply: ready=%b renorm=%b, required 0 0", req_if.req_ready, renorm);
        end
        @(posedge clk); #1;
        checks++;
        if (req_if.req_ready !== 1'b1 || rd_lru_count !== 16'h1032) begin
            errors++;
            $display("FAIL renorm_ranks: ready=%b row=%h, required 1 1032", req_if.req_ready, rd_lru_count);
        end
        @(posedge clk); #1;
        checks++;
        if (rd_lru_count !== 16'h1432) begin
            errors++;
            $display("FAIL renorm_final: row=%h, required 1432", rd_lru_count);
        end
        read_set(4'd2, row);
        checks++;
        if (row !== 16'h4301) begin
            errors++;
            $display("FAIL other_set: set 2 row=%h, required 4301", row);
        end
    endtask

    task automatic test_reset_in_renorm();
        fill_alt(4'd6);
        req_if.req_valid = 1'b1;
        req_if.req_op    = 1'b0;
        req_if.req_set   = 4'd6;
        req_if.req_way   = 2'd2;
        @(posedge clk); #1;
        req_if.req_valid = 1'b0;
        $display("req op=0 set=6 way=2 then reset in RENORM");
        checks++;
        if (renorm !== 1'b1) begin
            errors++;
            $display("FAIL rst_renorm_enter: renorm=%b, required 1", renorm);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (req_if.req_ready !== 1'b0 || renorm !== 1'b0 || rd_lru_count !== 16'h0000) begin
            errors++;
            $display("FAIL rst_renorm_outputs: ready=%b renorm=%b rd=%h, required 0 0 0000",
                     req_if.req_ready, renorm, rd_lru_count);
        end
        rst = 1'b0;
        wait_sweep();
        checks++;
        if (renorm !== 1'b0) begin
            errors++;
            $display("FAIL rst_renorm_pulse: renorm=%b, required 0", renorm);
        end
    endtask

    task automatic test_same_cycle_read();
        rd_set           = 4'd4;
        req_if.req_valid = 1'b1;
        req_if.req_op    = 1'b0;
        req_if.req_set   = 4'd4;
        req_if.req_way   = 2'd1;
        @(posedge clk); #1;
        req_if.req_valid = 1'b0;
        $display("req op=0 set=4 way=1 with read of set 4");
        checks++;
        if (rd_lru_count !== 16'h0000) begin
            errors++;
            $display("FAIL same_cycle_old: row=%h, required 0000", rd_lru_count);
        end
        @(posedge clk); #1;
        checks++;
        if (rd_lru_count !== 16'h0010) begin
            errors++;
            $display("FAIL same_cycle_new: row=%h, required 0010", rd_lru_count);
        end
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        rst              = 1'b1;
        rd_set           = '0;
        req_if.req_valid = 1'b0;
        req_if.req_op    = 1'b0;
        req_if.req_set   = '0;
        req_if.req_way   = '0;
        test_reset();
        test_back_to_back();
        test_touch_max_inval();
        test_renorm();
        test_reset_in_renorm();
        test_same_cycle_read();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
